// File: rtl/alu_wb_buffer.sv
// ALU writeback buffer: DEPTH-entry FIFO with sticky status and op counter.
// Define ALU_TRAP_EN to hold overflowing add/sub results at the head as traps.
module alu_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic                       in_zero,
  input  logic                       in_cout,
  input  logic                       in_overflow,
  input  logic [3:0]                 in_ctrl,
  input  logic [4:0]                 in_dest,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [4:0]                 out_dest,
  output logic                       out_zero,
  output logic                       out_wen,
  output logic                       trap,
  output logic                       ovf_sticky,
  output logic                       cout_sticky,
  input  logic                       clr_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           op_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CNT_W-1:0] OP_ONE = CNT_W'(1);

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        zero;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ovf_op;
  logic          cout_op;

  assign full      = (count == C_FULL);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  assign ovf_op  = in_overflow &&
                   (in_ctrl == 4'b0010 || in_ctrl == 4'b0110);
  assign cout_op = in_cout && (in_ctrl != 4'b0111);

  assign head       = mem[rd_ptr];
  assign out_result = head.result;
  assign out_dest   = head.dest;
  assign out_zero   = head.zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      op_count    <= '0;
      ovf_sticky  <= 1'b0;
      cout_sticky <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{result: in_result,
                         dest:   in_dest,
                         zero:   in_zero};
        wr_ptr   <= wr_ptr + P_ONE;
        op_count <= op_count + OP_ONE;
      end
      if (pop)
        rd_ptr <= rd_ptr + P_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
      // a set from this cycle's push beats a clear
      if (push && ovf_op)
        ovf_sticky <= 1'b1;
      else if (clr_flags)
        ovf_sticky <= 1'b0;
      if (push && cout_op)
        cout_sticky <= 1'b1;
      else if (clr_flags)
        cout_sticky <= 1'b0;
    end
  end

`ifdef ALU_TRAP_EN
  logic trap_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        trap_mem[i] <= 1'b0;
    end else if (push) begin
      trap_mem[wr_ptr] <= ovf_op;
    end
  end

  assign trap    = out_valid && trap_mem[rd_ptr];
  assign out_wen = out_valid && !trap_mem[rd_ptr];
`else
  assign trap    = 1'b0;
  assign out_wen = out_valid;
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Bench for alu_wb_buffer: directed table, wrap sequence, random vs model.
// Honours ALU_TRAP_EN for trap/out_wen expectations.
module tb_alu_wb_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef ALU_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic        in_cout;
  logic        in_overflow;
  logic [3:0]  in_ctrl;
  logic [4:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_zero;
  logic        out_wen;
  logic        trap;
  logic        ovf_sticky;
  logic        cout_sticky;
  logic        clr_flags;
  logic [2:0]  count;
  logic [CNT_W-1:0] op_count;

  alu_wb_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero),
    .in_cout(in_cout), .in_overflow(in_overflow),
    .in_ctrl(in_ctrl), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest),
    .out_zero(out_zero), .out_wen(out_wen),
    .trap(trap), .ovf_sticky(ovf_sticky),
    .cout_sticky(cout_sticky), .clr_flags(clr_flags),
    .count(count), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  d;
    logic        z;
    logic        t;
  } m_t;

  m_t q[$];
  logic m_ovf;
  logic m_co;
  logic [CNT_W-1:0] m_opc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mcheck();
    logic v;
    logic ht;
    v  = q.size() > 0;
    ht = v ? q[0].t : 1'b0;
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, v);
    chk("count", count, q.size());
    chk("op_count", op_count, m_opc);
    chk("ovf_sticky", ovf_sticky, m_ovf);
    chk("cout_sticky", cout_sticky, m_co);
    chk("out_wen", out_wen, v && !(TRAP && ht));
    chk("trap", trap, v && TRAP && ht);
    if (v) begin
      chk("out_result", out_result, q[0].r);
      chk("out_dest", out_dest, q[0].d);
      chk("out_zero", out_zero, q[0].z);
    end
  endtask

  // Advance one clock; the model sees the same pre-edge inputs.
  task automatic step();
    bit pu;
    bit po;
    bit addsub;
    m_t e;
    @(posedge clk);
    pu = in_valid && (q.size() < DEPTH);
    po = out_ready && (q.size() > 0);
    addsub = (in_ctrl == 4'b0010) || (in_ctrl == 4'b0110);
    if (pu && in_overflow && addsub) m_ovf = 1'b1;
    else if (clr_flags) m_ovf = 1'b0;
    if (pu && in_cout && in_ctrl != 4'b0111) m_co = 1'b1;
    else if (clr_flags) m_co = 1'b0;
    if (po) void'(q.pop_front());
    if (pu) begin
      e.r = in_result;
      e.d = in_dest;
      e.z = in_zero;
      e.t = in_overflow && addsub;
      q.push_back(e);
      m_opc = m_opc + 1'b1;
    end
    #1;
    mcheck();
  endtask

  task automatic drive(logic iv, logic [31:0] r, logic [4:0] d,
                       logic ov, logic co, logic [3:0] c,
                       logic ordy, logic clr);
    in_valid    = iv;
    in_result   = r;
    in_dest     = d;
    in_zero     = (r == 32'h0);
    in_overflow = ov;
    in_cout     = co;
    in_ctrl     = c;
    out_ready   = ordy;
    clr_flags   = clr;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] r;
    logic [4:0]  d;
    logic        ov;
    logic        co;
    logic [3:0]  c;
    logic        ordy;
    logic        clr;
    logic [2:0]  e_cnt;
    logic        e_vld;
    logic [31:0] e_res;
    logic        e_htrap;
    logic        e_ovf;
    logic        e_co;
    logic [15:0] e_opc;
  } vec_t;

  vec_t tbl[12];

  logic [3:0] ctl_set[5];
  logic [CNT_W-1:0] op0;

  initial begin
    ctl_set = '{4'b0000, 4'b0010, 4'b0110, 4'b0111, 4'b0001};
    //         iv r   d  ov co ctl     ordy clr cnt vld res htr ovf co opc
    tbl[0]  = '{1, 5,  3, 0, 0, 4'b0000, 1, 0, 1, 1, 5,  0, 0, 0, 1};
    tbl[1]  = '{0, 0,  0, 0, 0, 4'b0000, 1, 0, 0, 0, 0,  0, 0, 0, 1};
    tbl[2]  = '{1, 7,  1, 1, 0, 4'b0010, 0, 0, 1, 1, 7,  1, 1, 0, 2};
    tbl[3]  = '{1, 8,  2, 1, 0, 4'b0110, 0, 1, 2, 1, 7,  1, 1, 0, 3};
    tbl[4]  = '{0, 0,  0, 0, 0, 4'b0000, 0, 1, 2, 1, 7,  1, 0, 0, 3};
    tbl[5]  = '{1, 9,  4, 0, 1, 4'b0111, 0, 0, 3, 1, 7,  1, 0, 0, 4};
    tbl[6]  = '{1, 10, 5, 0, 1, 4'b0010, 0, 0, 4, 1, 7,  1, 0, 1, 5};
    tbl[7]  = '{1, 11, 6, 1, 0, 4'b0010, 0, 0, 4, 1, 7,  1, 0, 1, 5};
    tbl[8]  = '{0, 0,  0, 0, 0, 4'b0000, 1, 0, 3, 1, 8,  1, 0, 1, 5};
    tbl[9]  = '{0, 0,  0, 0, 0, 4'b0000, 1, 0, 2, 1, 9,  0, 0, 1, 5};
    tbl[10] = '{0, 0,  0, 0, 0, 4'b0000, 1, 0, 1, 1, 10, 0, 0, 1, 5};
    tbl[11] = '{0, 0,  0, 0, 0, 4'b0000, 1, 0, 0, 0, 0,  0, 0, 1, 5};

    q.delete();
    m_ovf = 1'b0;
    m_co  = 1'b0;
    m_opc = '0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 4'b0000, 0, 0);
    #8;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_wen", out_wen, 0);
    chk("rst_trap", trap, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_sticky", {ovf_sticky, cout_sticky}, 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].r, tbl[i].d, tbl[i].ov, tbl[i].co,
            tbl[i].c, tbl[i].ordy, tbl[i].clr);
      step();
      chk($sformatf("t%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("t%0d_valid", i), out_valid, tbl[i].e_vld);
      if (tbl[i].e_vld)
        chk($sformatf("t%0d_result", i), out_result, tbl[i].e_res);
      chk($sformatf("t%0d_wen", i), out_wen,
          tbl[i].e_vld && !(TRAP && tbl[i].e_htrap));
      chk($sformatf("t%0d_trap", i), trap,
          tbl[i].e_vld && TRAP && tbl[i].e_htrap);
      chk($sformatf("t%0d_ovf", i), ovf_sticky, tbl[i].e_ovf);
      chk($sformatf("t%0d_cout", i), cout_sticky, tbl[i].e_co);
      chk($sformatf("t%0d_opc", i), op_count, tbl[i].e_opc);
      chk($sformatf("t%0d_ready", i), in_ready, tbl[i].e_cnt != 3'd4);
    end

    // two resident entries, push+pop every cycle across pointer wrap
    drive(1, 32'hA0, 7, 0, 0, 4'b0000, 0, 0);
    step();
    drive(1, 32'hA1, 8, 0, 0, 4'b0000, 0, 0);
    step();
    op0 = m_opc;
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, 5'($urandom), 0, 0, 4'b0000, 1, 0);
      step();
      chk("steady_count", count, 2);
    end
    chk("steady_opc", op_count, op0 + 16'd10);
    drive(0, 0, 0, 0, 0, 4'b0000, 1, 0);
    repeat (3) step();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ?
            32'h0 : $urandom, 5'($urandom),
            1'($urandom), 1'($urandom),
            ctl_set[$urandom_range(0, 4)],
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      step();
    end

    // asynchronous reset mid-cycle with three entries held
    drive(0, 0, 0, 0, 0, 4'b0000, 1, 0);
    repeat (5) step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + i, 5'(i), 1, 1, 4'b0010, 0, 0);
      step();
    end
    chk("pre_rst_count", count, 3);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_co  = 1'b0;
    m_opc = '0;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_ovf", ovf_sticky, 0);
    chk("arst_cout", cout_sticky, 0);
    chk("arst_result", out_result, 0);
    chk("arst_wen", out_wen, 0);
    chk("arst_trap", trap, 0);
    drive(0, 0, 0, 0, 0, 4'b0000, 1, 0);
    #2 rst_n = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
